mon_prod: RTL and testbench

Bit-serial radix-2 Montgomery product engine: computes P = A·B·2^(−mp_count) mod M on operands held in an external single-port-style operand memory, and writes the result back. It sits under the modular-exponentiation controller, which selects the product type with op_code, pulses start, and waits for the rising edge of stop.

---
 rtl/mon_prod_if.sv | 15 +
 rtl/mon_prod.sv | 172 +++++++++++++++++
 tb/tb_mon_prod.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mon_prod_if.sv
// Operand-memory bus between mon_prod (master) and the operand store (slave).
// Read data is returned one cycle after the read address is presented.
interface mon_prod_if #(
    parameter int unsigned ABITS = 8,
    parameter int unsigned DBITS = 512
) ();
    logic [ABITS-1:0] rd_addr;
    logic [DBITS-1:0] rd_data;
    logic [ABITS-1:0] wr_addr;
    logic [DBITS-1:0] wr_data;
    logic             wr_en;

    modport master (output rd_addr, wr_addr, wr_data, wr_en, input rd_data);
    modport slave  (input rd_addr, wr_addr, wr_data, wr_en, output rd_data);
endinterface

// File: rtl/mon_prod.sv
// Bit-serial radix-2 Montgomery product P = A*B*2^-k mod M over an external operand memory.
// Define MON_PROD_TRACE_EN for a simulation-only trace line at each write-back.
module mon_prod #(
    parameter int unsigned ABITS      = 8,
    parameter int unsigned DBITS      = 512,
    parameter int unsigned BITLEN     = 512,
    parameter int unsigned LOG_BITLEN = 9,
    parameter int unsigned X_ADDR     = 0,
    parameter int unsigned MBAR_ADDR  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op_code,
    input  logic [BITLEN-1:0]     M,
    input  logic [LOG_BITLEN:0]   mp_count,
    mon_prod_if.master            bus,
    output logic                  stop,
    output logic [BITLEN-1:0]     P
);
    localparam int unsigned SW = BITLEN + 2;
    localparam int unsigned KW = LOG_BITLEN + 1;

    typedef enum logic [2:0] {
        StIdle, StRdA, StRdB, StLatB, StIter, StFinal, StWrite
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [BITLEN-1:0] m_q, m_d;
    logic [KW-1:0]     k_q, k_d;
    logic [KW-1:0]     cnt_q, cnt_d;
    logic [BITLEN-1:0] a_q, a_d;
    logic [BITLEN-1:0] b_q, b_d;
    logic [SW-1:0]     s_q, s_d;
    logic [ABITS-1:0]  rd_addr_q, rd_addr_d;
    logic [ABITS-1:0]  wr_addr_q, wr_addr_d;
    logic [BITLEN-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              stop_q, stop_d;
    logic [BITLEN-1:0] p_q, p_d;

    logic [DBITS-1:0]  rd_word;
    logic [KW-1:0]     k_clamp;
    logic [SW-1:0]     s_add, s_odd, s_fin;

    assign rd_word = bus.rd_data;
    assign k_clamp = (mp_count > KW'(BITLEN)) ? KW'(BITLEN) : mp_count;

    // A and B are below M, so S stays below 2M and BITLEN+2 bits never overflow.
    assign s_add = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    assign s_odd = s_add + (s_add[0] ? {2'b00, m_q} : '0);
    assign s_fin = (s_q >= {2'b00, m_q}) ? s_q - {2'b00, m_q} : s_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        m_d       = m_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        stop_d    = 1'b0;
        p_d       = p_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op_code;
                    m_d       = M;
                    k_d       = k_clamp;
                    rd_addr_d = (op_code == 2'd1) ? ABITS'(MBAR_ADDR) : ABITS'(X_ADDR);
                    state_d   = StRdA;
                end
            end
            StRdA: begin
                rd_addr_d = ABITS'(X_ADDR);
                state_d   = StRdB;
            end
            StRdB: begin
                // OPX1 still performs the read so every op code has the same latency.
                a_d     = (op_q == 2'd2) ? BITLEN'(1) : rd_word[BITLEN-1:0];
                state_d = StLatB;
            end
            StLatB: begin
                b_d     = rd_word[BITLEN-1:0];
                s_d     = '0;
                cnt_d   = k_q;
                state_d = (k_q == '0) ? StFinal : StIter;
            end
            StIter: begin
                s_d   = s_odd >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q - KW'(1);
                if (cnt_q == KW'(1)) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                s_d       = s_fin;
                wr_en_d   = 1'b1;
                stop_d    = 1'b1;
                wr_addr_d = ABITS'(X_ADDR);
                wr_data_d = s_fin[BITLEN-1:0];
                p_d       = s_fin[BITLEN-1:0];
                state_d   = StWrite;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            m_q       <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            stop_q    <= 1'b0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            m_q       <= m_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            stop_q    <= stop_d;
            p_q       <= p_d;
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = DBITS'(wr_data_q);
    assign bus.wr_en   = wr_en_q;
    assign stop        = stop_q;
    assign P           = p_q;

`ifdef MON_PROD_TRACE_EN
    logic [BITLEN-1:0] a_trace_q;

    always @(posedge clk) begin
        if (state_q == StRdB) a_trace_q <= a_d;
        if (state_q == StFinal) begin
            $display("mon_prod: op=%0d A=%h B=%h M=%h k=%0d P=%h",
                     op_q, a_trace_q, b_q, m_q, k_q, s_fin[BITLEN-1:0]);
        end
    end
`else
    // Trace disabled: no simulation-only logic.
`endif

endmodule

// File: tb/tb_mon_prod.sv
// Self-checking bench for mon_prod: directed small-modulus cases plus random 512-bit products
// checked against an arithmetic model (A*B mod M, then k modular halvings).
module tb_mon_prod;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op_code = '0;
    logic [511:0] M = '0;
    logic [9:0]   mp_count = '0;
    logic         stop;
    logic [511:0] P;

    mon_prod_if #(.ABITS(8), .DBITS(512)) bus ();

    mon_prod dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_code  (op_code),
        .M        (M),
        .mp_count (mp_count),
        .bus      (bus.master),
        .stop     (stop),
        .P        (P)
    );

    always #5 clk = ~clk;

    logic [511:0] mem [0:255];
    logic         tb_we = 1'b0;
    logic [7:0]   tb_wa = '0;
    logic [511:0] tb_wd = '0;

    always @(posedge clk) begin
        bus.rd_data <= mem[bus.rd_addr];
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (tb_we) mem[tb_wa] <= tb_wd;
    end

    int n_checks = 0;
    int n_fail = 0;
    int stop_total = 0;
    int wr_total = 0;
    int long_stop = 0;
    logic stop_prev = 1'b0;

    always @(negedge clk) begin
        if (stop) stop_total++;
        if (bus.wr_en) wr_total++;
        if (stop && stop_prev) long_stop++;
        stop_prev = stop;
    end

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: reduce A*B mod M, then divide by 2 modulo M k times.
    function automatic logic [511:0] ref_prod(input logic [511:0] a, input logic [511:0] b,
                                              input logic [511:0] m, input int k);
        logic [1023:0] prod;
        logic [1023:0] mw;
        logic [512:0]  r;
        prod = {512'b0, a} * {512'b0, b};
        mw   = {512'b0, m};
        prod = prod % mw;
        r    = prod[512:0];
        for (int i = 0; i < k; i++) r = r[0] ? (r + {1'b0, m}) >> 1 : r >> 1;
        return r[511:0];
    endfunction

    // Called at a negedge; writes one word before the next posedge.
    task automatic set_mem(input logic [7:0] a, input logic [511:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge one cycle after stop (DUT idle again).
    task automatic run_op(input logic [1:0] op, input logic [511:0] m, input int mp,
                          input bit poke, output int cyc, output logic [7:0] ra1,
                          output logic [7:0] ra2, output int wrs, output logic stop_after);
        op_code = op; M = m; mp_count = 10'(mp); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; wrs = 0; ra1 = bus.rd_addr; ra2 = '0;
        while (!stop && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) ra2 = bus.rd_addr;
            if (poke && cyc == 10) begin start = 1'b1; op_code = 2'd2; end
            else start = 1'b0;
            if (bus.wr_en) wrs++;
        end
        start = 1'b0;
        @(negedge clk);
        stop_after = stop;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop got %0b want 0", stop); end
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %0b want 0", bus.wr_en); end
        n_checks++; if (bus.rd_addr !== 8'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0h want 0", bus.rd_addr); end
        n_checks++; if (bus.wr_addr !== 8'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0h want 0", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 512'd0) begin n_fail++; $display("FAIL reset_wr_data got %0h want 0", bus.wr_data); end
        n_checks++; if (P !== 512'd0) begin n_fail++; $display("FAIL reset_P got %0h want 0", P); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_opxx();
        int cyc, wrs; logic [7:0] ra1, ra2; logic sa;
        set_mem(8'd0, 512'd5);
        run_op(2'd0, 512'd13, 4, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL opxx_latency got %0d want 9", cyc); end
        n_checks++; if (P !== 512'd4) begin n_fail++; $display("FAIL opxx_P got %0d want 4", P); end
        n_checks++; if (bus.wr_data !== 512'd4) begin n_fail++; $display("FAIL opxx_wr_data got %0d want 4", bus.wr_data); end
        n_checks++; if (mem[0] !== 512'd4) begin n_fail++; $display("FAIL opxx_mem0 got %0d want 4", mem[0]); end
        n_checks++; if (wrs !== 1) begin n_fail++; $display("FAIL opxx_wr_pulses got %0d want 1", wrs); end
        n_checks++; if (sa !== 1'b0) begin n_fail++; $display("FAIL opxx_stop_width got %0b want 0", sa); end
        n_checks++; if (ra1 !== 8'd0) begin n_fail++; $display("FAIL opxx_rd_addr1 got %0d want 0", ra1); end
    endtask

    task automatic test_opxm();
        int cyc, wrs; logic [7:0] ra1, ra2; logic sa;
        set_mem(8'd1, 512'd7);
        set_mem(8'd0, 512'd5);
        run_op(2'd1, 512'd13, 4, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (P !== 512'd3) begin n_fail++; $display("FAIL opxm_P got %0d want 3", P); end
        n_checks++; if (ra1 !== 8'd1) begin n_fail++; $display("FAIL opxm_rd_addr1 got %0d want 1", ra1); end
        n_checks++; if (ra2 !== 8'd0) begin n_fail++; $display("FAIL opxm_rd_addr2 got %0d want 0", ra2); end
        n_checks++; if (mem[0] !== 512'd3) begin n_fail++; $display("FAIL opxm_mem0 got %0d want 3", mem[0]); end
    endtask

    task automatic test_opx1();
        int cyc, wrs; logic [7:0] ra1, ra2; logic sa;
        set_mem(8'd0, 512'd5);
        run_op(2'd2, 512'd13, 4, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (P !== 512'd6) begin n_fail++; $display("FAIL opx1_P got %0d want 6", P); end
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL opx1_latency got %0d want 9", cyc); end
    endtask

    task automatic test_k_zero();
        int cyc, wrs; logic [7:0] ra1, ra2; logic sa;
        set_mem(8'd0, 512'd9);
        set_mem(8'd1, 512'd11);
        run_op(2'd1, 512'd13, 0, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (P !== 512'd0) begin n_fail++; $display("FAIL k0_P got %0d want 0", P); end
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL k0_latency got %0d want 5", cyc); end
        n_checks++; if (wrs !== 1) begin n_fail++; $display("FAIL k0_wr_pulses got %0d want 1", wrs); end
    endtask

    task automatic test_back_to_back();
        int cyc, wrs; logic [7:0] ra1, ra2; logic sa;
        logic [511:0] exp1, exp2;
        exp1 = ref_prod(512'd5, 512'd5, 512'd13, 4);
        exp2 = ref_prod(exp1, exp1, 512'd13, 4);
        set_mem(8'd0, 512'd5);
        run_op(2'd0, 512'd13, 4, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (P !== exp1) begin n_fail++; $display("FAIL b2b_first_P got %0d want %0d", P, exp1); end
        run_op(2'd0, 512'd13, 4, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 9", cyc); end
        n_checks++; if (P !== exp2) begin n_fail++; $display("FAIL b2b_second_P got %0d want %0d", P, exp2); end
    endtask

    task automatic test_reset_mid();
        int s0, w0, cyc, wrs; logic [7:0] ra1, ra2; logic sa;
        set_mem(8'd0, 512'd5);
        op_code = 2'd0; M = 512'd13; mp_count = 10'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (P !== 512'd0) begin n_fail++; $display("FAIL midrst_P got %0d want 0", P); end
        n_checks++; if (bus.wr_data !== 512'd0) begin n_fail++; $display("FAIL midrst_wr_data got %0d want 0", bus.wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
        s0 = stop_total; w0 = wr_total;
        repeat (250) @(negedge clk);
        n_checks++; if (stop_total !== s0) begin n_fail++; $display("FAIL midrst_stop got %0d pulses want 0", stop_total - s0); end
        n_checks++; if (wr_total !== w0) begin n_fail++; $display("FAIL midrst_wr_en got %0d pulses want 0", wr_total - w0); end
        n_checks++; if (mem[0] !== 512'd5) begin n_fail++; $display("FAIL midrst_mem0 got %0d want 5", mem[0]); end
        run_op(2'd0, 512'd13, 4, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (P !== 512'd4) begin n_fail++; $display("FAIL midrst_restart_P got %0d want 4", P); end
    endtask

    task automatic test_clamp();
        int cyc, wrs; logic [7:0] ra1, ra2; logic sa;
        logic [511:0] exp;
        exp = ref_prod(512'd5, 512'd5, 512'd13, 512);
        set_mem(8'd0, 512'd5);
        run_op(2'd0, 512'd13, 700, 1'b0, cyc, ra1, ra2, wrs, sa);
        n_checks++; if (cyc !== 517) begin n_fail++; $display("FAIL clamp_latency got %0d want 517", cyc); end
        n_checks++; if (P !== exp) begin n_fail++; $display("FAIL clamp_P got %0d want %0d", P, exp); end
    endtask

    task automatic test_random_wide();
        int cyc, wrs, s0; logic [7:0] ra1, ra2; logic sa;
        logic [511:0] m, x, mb, a, b, exp;
        logic [1:0] ops [4];
        ops[0] = 2'd1; ops[1] = 2'd0; ops[2] = 2'd2; ops[3] = 2'd3;
        for (int t = 0; t < 4; t++) begin
            m  = rand512();
            m[0] = 1'b1; m[511] = 1'b1;
            x  = rand512() % m;
            mb = rand512() % m;
            set_mem(8'd0, x);
            set_mem(8'd1, mb);
            a = (ops[t] == 2'd1) ? mb : (ops[t] == 2'd2) ? 512'd1 : x;
            b = x;
            exp = ref_prod(a, b, m, 512);
            run_op(ops[t], m, 512, (t == 0), cyc, ra1, ra2, wrs, sa);
            n_checks++; if (P !== exp) begin n_fail++; $display("FAIL rand%0d_P op=%0d got %h want %h", t, ops[t], P, exp); end
            n_checks++; if (mem[0] !== exp) begin n_fail++; $display("FAIL rand%0d_mem0 got %h want %h", t, mem[0], exp); end
            n_checks++; if (cyc !== 517) begin n_fail++; $display("FAIL rand%0d_latency got %0d want 517", t, cyc); end
            if (t == 0) begin
                s0 = stop_total;
                repeat (30) @(negedge clk);
                n_checks++; if (stop_total !== s0) begin n_fail++; $display("FAIL busy_start_accepted got %0d extra stops want 0", stop_total - s0); end
            end
        end
        n_checks++; if (long_stop !== 0) begin n_fail++; $display("FAIL stop_held got %0d long pulses want 0", long_stop); end
    endtask

    initial begin
        test_reset();
        test_opxx();
        test_opxm();
        test_opx1();
        test_k_zero();
        test_back_to_back();
        test_reset_mid();
        test_clamp();
        test_random_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
